// File: rtl/mdu_if.sv
// Multiply/divide unit issue and result bundle.
// Master side issues ops; slave side (mdu) reports busy and HI/LO.
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, srcA, srcB,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, srcA, srcB,
        output busy, hi, lo
    );
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu (ops 7-10).
module mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic clk,
    input logic reset,
    mdu_if.slave bus
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                          MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] MULT_CNT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] LAST_CNT = CW'(1);
    localparam logic [WIDTH-1:0] MIN_INT =
        {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cntNext;
    logic [WIDTH-1:0] hiQ;
    logic [WIDTH-1:0] loQ;
    logic [WIDTH-1:0] hiNext;
    logic [WIDTH-1:0] loNext;
    logic [WIDTH-1:0] pendHi;
    logic [WIDTH-1:0] pendLo;
    logic [WIDTH-1:0] pendHiNext;
    logic [WIDTH-1:0] pendLoNext;
    logic             pendWr;
    logic             pendWrNext;

    logic opMult;
    logic opMultu;
    logic opDiv;
    logic opDivu;
    logic opMthi;
    logic opMtlo;

    assign opMult  = (bus.op == 4'd1);
    assign opMultu = (bus.op == 4'd2);
    assign opDiv   = (bus.op == 4'd3);
    assign opDivu  = (bus.op == 4'd4);
    assign opMthi  = (bus.op == 4'd5);
    assign opMtlo  = (bus.op == 4'd6);

    logic signed [2*WIDTH-1:0] aExt;
    logic signed [2*WIDTH-1:0] bExt;
    logic [2*WIDTH-1:0]        prodS;
    logic [2*WIDTH-1:0]        prodU;

    assign aExt  = {{WIDTH{bus.srcA[WIDTH-1]}}, bus.srcA};
    assign bExt  = {{WIDTH{bus.srcB[WIDTH-1]}}, bus.srcB};
    assign prodS = aExt * bExt;
    assign prodU = {{WIDTH{1'b0}}, bus.srcA} *
                   {{WIDTH{1'b0}}, bus.srcB};

`ifdef MDU_MADD_EN
    logic opMadd;
    logic opMaddu;
    logic opMsub;
    logic opMsubu;
    logic [2*WIDTH-1:0] acc;

    assign opMadd  = (bus.op == 4'd7);
    assign opMaddu = (bus.op == 4'd8);
    assign opMsub  = (bus.op == 4'd9);
    assign opMsubu = (bus.op == 4'd10);
    assign acc     = {hiQ, loQ};
`endif

    logic             divZero;
    logic             divOvf;
    logic [WIDTH-1:0] quotS;
    logic [WIDTH-1:0] remS;
    logic [WIDTH-1:0] quotU;
    logic [WIDTH-1:0] remU;

    assign divZero = (bus.srcB == '0);
    assign divOvf  = (bus.srcA == MIN_INT) && (bus.srcB == '1);

    // Divider: guarded so a zero divisor or MIN/-1 never feeds the operator.
    always_comb begin
        quotS = '0;
        remS  = '0;
        quotU = '0;
        remU  = '0;
        if (!divZero) begin
            quotU = bus.srcA / bus.srcB;
            remU  = bus.srcA % bus.srcB;
            if (!divOvf) begin
                quotS = $signed(bus.srcA) / $signed(bus.srcB);
                remS  = $signed(bus.srcA) % $signed(bus.srcB);
            end
        end
    end

    // Next state: issue latches the result, RUN counts down and commits.
    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        hiNext     = hiQ;
        loNext     = loQ;
        pendHiNext = pendHi;
        pendLoNext = pendLo;
        pendWrNext = pendWr;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    unique case (1'b1)
                        opMult: begin
                            {pendHiNext, pendLoNext} = prodS;
                            pendWrNext = 1'b1;
                            cntNext    = MULT_CNT;
                            stateNext  = RUN;
                        end
                        opMultu: begin
                            {pendHiNext, pendLoNext} = prodU;
                            pendWrNext = 1'b1;
                            cntNext    = MULT_CNT;
                            stateNext  = RUN;
                        end
                        opDiv: begin
                            pendHiNext = divOvf ? '0 : remS;
                            pendLoNext = divOvf ? MIN_INT : quotS;
                            pendWrNext = !divZero;
                            cntNext    = DIV_CNT;
                            stateNext  = RUN;
                        end
                        opDivu: begin
                            pendHiNext = remU;
                            pendLoNext = quotU;
                            pendWrNext = !divZero;
                            cntNext    = DIV_CNT;
                            stateNext  = RUN;
                        end
                        opMthi: begin
                            hiNext = bus.srcA;
                        end
                        opMtlo: begin
                            loNext = bus.srcA;
                        end
`ifdef MDU_MADD_EN
                        opMadd: begin
                            {pendHiNext, pendLoNext} = acc + prodS;
                            pendWrNext = 1'b1;
                            cntNext    = MULT_CNT;
                            stateNext  = RUN;
                        end
                        opMaddu: begin
                            {pendHiNext, pendLoNext} = acc + prodU;
                            pendWrNext = 1'b1;
                            cntNext    = MULT_CNT;
                            stateNext  = RUN;
                        end
                        opMsub: begin
                            {pendHiNext, pendLoNext} = acc - prodS;
                            pendWrNext = 1'b1;
                            cntNext    = MULT_CNT;
                            stateNext  = RUN;
                        end
                        opMsubu: begin
                            {pendHiNext, pendLoNext} = acc - prodU;
                            pendWrNext = 1'b1;
                            cntNext    = MULT_CNT;
                            stateNext  = RUN;
                        end
`endif
                        default: begin
                        end
                    endcase
                end
            end
            RUN: begin
                cntNext = cnt - 1'b1;
                if (cnt == LAST_CNT) begin
                    stateNext  = IDLE;
                    pendWrNext = 1'b0;
                    if (pendWr) begin
                        hiNext = pendHi;
                        loNext = pendLo;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State, counter, pending result and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            hiQ    <= '0;
            loQ    <= '0;
            pendHi <= '0;
            pendLo <= '0;
            pendWr <= 1'b0;
        end else begin
            state  <= stateNext;
            cnt    <= cntNext;
            hiQ    <= hiNext;
            loQ    <= loNext;
            pendHi <= pendHiNext;
            pendLo <= pendLoNext;
            pendWr <= pendWrNext;
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.hi   = hiQ;
    assign bus.lo   = loQ;
endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases then random ops
// compared against a plain-arithmetic HI/LO model.
module tb_mdu;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [63:0] mdl;

    mdu_if #(.WIDTH(32)) bus ();

    mdu #(
        .WIDTH(32),
        .MULT_CYCLES(5),
        .DIV_CYCLES(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [3:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [63:0] cur);
        longint sa;
        longint sb;
        longint unsigned ua;
        longint unsigned ub;
        int q;
        int r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        model = cur;
        case (o)
            4'd1: model = sa * sb;
            4'd2: model = ua * ub;
            4'd3: begin
                if (b != 0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        model = {32'd0, a};
                    end else begin
                        q = int'($signed(a)) / int'($signed(b));
                        r = int'($signed(a)) - q * int'($signed(b));
                        model = {r, q};
                    end
                end
            end
            4'd4: if (b != 0) model = {a % b, a / b};
            4'd5: model = {a, cur[31:0]};
            4'd6: model = {cur[63:32], a};
`ifdef MDU_MADD_EN
            4'd7:  model = cur + sa * sb;
            4'd8:  model = cur + ua * ub;
            4'd9:  model = cur - sa * sb;
            4'd10: model = cur - ua * ub;
`endif
            default: ;
        endcase
    endfunction

    function automatic int latency(input logic [3:0] o);
        latency = 0;
        if (o == 4'd1 || o == 4'd2) latency = 5;
        if (o == 4'd3 || o == 4'd4) latency = 10;
`ifdef MDU_MADD_EN
        if (o >= 4'd7 && o <= 4'd10) latency = 5;
`endif
    endfunction

    function automatic logic [31:0] pickVal();
        case ($urandom_range(0, 7))
            0: pickVal = 32'd0;
            1: pickVal = 32'hFFFF_FFFF;
            2: pickVal = 32'h8000_0000;
            3: pickVal = 32'd1;
            default: pickVal = $urandom;
        endcase
    endfunction

    task automatic doOp(input string tag, input logic [3:0] o,
                        input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int lat;
        int n;
        exp = model(o, a, b, mdl);
        lat = latency(o);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.srcA  = a;
        bus.srcB  = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 4'd0;
        bus.srcA  = $urandom;
        bus.srcB  = $urandom;
        if (lat > 0) chk({tag, ".hold"}, {bus.hi, bus.lo}, mdl);
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk({tag, ".busy"}, 64'(n), 64'(lat));
        chk({tag, ".hilo"}, {bus.hi, bus.lo}, exp);
        mdl = exp;
    endtask

    initial begin
        logic [63:0] exp;
        logic [3:0]  o;
        int n;
        logic [3:0] ops [13] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
                                 4'd6, 4'd7, 4'd8, 4'd9, 4'd10,
                                 4'd11, 4'd15};
        checks    = 0;
        errors    = 0;
        mdl       = 64'd0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 4'd0;
        bus.srcA  = 32'd0;
        bus.srcB  = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset.busy", 64'(bus.busy), 64'd0);
        chk("reset.hilo", {bus.hi, bus.lo}, 64'd0);

        doOp("mult", 4'd1, 32'hFFFF_FFFD, 32'd7);
        chk("mult.const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        doOp("multu", 4'd2, 32'hFFFF_FFFF, 32'd2);
        chk("multu.const", {bus.hi, bus.lo}, 64'h0000_0001_FFFF_FFFE);
        doOp("div", 4'd3, 32'hFFFF_FFF9, 32'd2);
        chk("div.const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        doOp("mthi11", 4'd5, 32'h11, 32'd0);
        doOp("mtlo22", 4'd6, 32'h22, 32'd0);
        doOp("divu0", 4'd4, 32'd7, 32'd0);
        chk("divu0.const", {bus.hi, bus.lo}, 64'h0000_0011_0000_0022);
        doOp("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);

        // mthi while a div is in flight must be dropped
        exp = model(4'd3, 32'd100, 32'd7, mdl);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 4'd3;
        bus.srcA  = 32'd100;
        bus.srcB  = 32'd7;
        @(negedge clk);
        bus.op    = 4'd5;
        bus.srcA  = 32'hABCD;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 4'd0;
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("busyign.cycles", 64'(n), 64'd9);
        chk("busyign.hilo", {bus.hi, bus.lo}, exp);
        chk("busyign.const", {bus.hi, bus.lo}, 64'h0000_0002_0000_000E);
        mdl = exp;
        doOp("mthiAB", 4'd5, 32'hABCD, 32'd0);
        chk("mthiAB.hi", 64'(bus.hi), 64'hABCD);

        doOp("nop", 4'd0, 32'd5, 32'd6);
        doOp("undef11", 4'd11, 32'd5, 32'd6);
        doOp("undef15", 4'd15, 32'd5, 32'd6);

        for (int i = 0; i < 40; i++) begin
            o = ops[$urandom_range(0, 12)];
            doOp($sformatf("rnd%0d.op%0d", i, o), o, pickVal(), pickVal());
        end

        // reset on the 4th busy cycle of a div aborts it
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 4'd3;
        bus.srcA  = 32'd1000;
        bus.srcB  = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 4'd0;
        repeat (3) @(negedge clk);
        chk("abort.busy4", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort.busy", 64'(bus.busy), 64'd0);
        chk("abort.hilo", {bus.hi, bus.lo}, 64'd0);
        repeat (12) @(negedge clk);
        chk("abort.late.busy", 64'(bus.busy), 64'd0);
        chk("abort.late.hilo", {bus.hi, bus.lo}, 64'd0);
        mdl = 64'd0;
        doOp("mtlo5", 4'd6, 32'd5, 32'd0);
        doOp("madd", 4'd7, 32'd3, 32'd4);
`ifdef MDU_MADD_EN
        chk("madd.const", {bus.hi, bus.lo}, 64'd17);
`else
        chk("madd.off", {bus.hi, bus.lo}, 64'd5);
`endif
        doOp("msub", 4'd9, 32'hFFFF_FFFF, 32'd9);
        doOp("msubu", 4'd10, 32'hFFFF_FFFF, 32'd9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
